// File: rtl/snake_pkg.sv
// Shared types for the snake game-flow sequencer: direction codes, FSM states and
// the small helpers that map between them.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_READY,
        ST_RUN,
        ST_STEP,
        ST_OVER
    } state_e;

    localparam logic [1:0] GS_INIT  = 2'd0;
    localparam logic [1:0] GS_READY = 2'd1;
    localparam logic [1:0] GS_RUN   = 2'd2;
    localparam logic [1:0] GS_OVER  = 2'd3;

    // Opposite directions differ only in the LSB of their code.
    function automatic dir_e opposite(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

    function automatic logic [1:0] game_code(input state_e s);
        case (s)
            ST_INIT:          return GS_INIT;
            ST_READY:         return GS_READY;
            ST_RUN, ST_STEP:  return GS_RUN;
            default:          return GS_OVER;
        endcase
    endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Synchronises the raw direction switches, priority-encodes them (up>down>left>right)
// and keeps a pending direction that never reverses the direction about to be committed.
module snake_dir_latch
    import snake_pkg::*;
(
    input  logic vga_clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic sw_up_i,
    input  logic sw_down_i,
    input  logic sw_left_i,
    input  logic sw_right_i,
    input  dir_e committed_dir_i,
    output dir_e pending_o,
    output logic turn_o
);

    logic [3:0] sw_meta_q, sw_sync_q;
    dir_e       pending_q, pending_d;
    dir_e       req_dir;
    logic       req_valid;

    // NOTE: every register resets asynchronously, so the outputs are defined the instant
    // rst_i rises, before any clock edge.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            pending_q <= DIR_RIGHT;
        end else begin
            sw_meta_q <= {sw_up_i, sw_down_i, sw_left_i, sw_right_i};
            sw_sync_q <= sw_meta_q;
            pending_q <= pending_d;
        end
    end

    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_RIGHT;
        pending_d = pending_q;
        if      (sw_sync_q[3]) req_dir = DIR_UP;
        else if (sw_sync_q[2]) req_dir = DIR_DOWN;
        else if (sw_sync_q[1]) req_dir = DIR_LEFT;
        else if (sw_sync_q[0]) req_dir = DIR_RIGHT;
        else                   req_valid = 1'b0;

        turn_o = req_valid && (req_dir != opposite(committed_dir_i));
        if (clear_i)     pending_d = DIR_RIGHT;
        else if (turn_o) pending_d = req_dir;
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/snake_step_scheduler.sv
// Game-flow sequencer: turns refresh frames into step requests with a req/ack handshake,
// commits the player direction per step, and tracks score and speed level.
module snake_step_scheduler
    import snake_pkg::*;
#(
    parameter int START_FRAMES  = 8,
    parameter int MIN_FRAMES    = 2,
    parameter int SPEEDUP_EVERY = 4,
    parameter int SCORE_W       = 8
) (
    input  logic               vga_clk_i,
    input  logic               rst_i,
    input  logic               refresh_i,
    input  logic               restart_i,
    input  logic               sw_up_i,
    input  logic               sw_down_i,
    input  logic               sw_left_i,
    input  logic               sw_right_i,
    input  logic               step_ack_i,
    input  logic               collision_i,
    input  logic               grow_i,
    output logic               init_req_o,
    output logic               step_req_o,
    output logic [1:0]         dir_o,
    output logic [1:0]         game_state_o,
    output logic [SCORE_W-1:0] score_o
);

    localparam int CNT_W  = $clog2(START_FRAMES + 1);
    localparam int GROW_W = $clog2(SPEEDUP_EVERY + 1);
    localparam logic [CNT_W-1:0]  START_C   = CNT_W'(START_FRAMES);
    localparam logic [CNT_W-1:0]  MAX_LVL   = CNT_W'(START_FRAMES - MIN_FRAMES);
    localparam logic [GROW_W-1:0] GROW_LAST = GROW_W'(SPEEDUP_EVERY - 1);

    state_e              state_q, state_d;
    dir_e                dir_q, dir_d;
    dir_e                pending_dir;
    logic                turn;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    level_q, level_d;
    logic [CNT_W-1:0]    frames;
    logic [GROW_W-1:0]   grow_cnt_q, grow_cnt_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                ref_meta_q, ref_sync_q, ref_prev_q, tick_q;

    snake_dir_latch u_dir_latch (
        .vga_clk_i       (vga_clk_i),
        .rst_i           (rst_i),
        .clear_i         (restart_i),
        .sw_up_i         (sw_up_i),
        .sw_down_i       (sw_down_i),
        .sw_left_i       (sw_left_i),
        .sw_right_i      (sw_right_i),
        .committed_dir_i (dir_d),
        .pending_o       (pending_dir),
        .turn_o          (turn)
    );

    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            ref_meta_q <= 1'b0;
            ref_sync_q <= 1'b0;
            ref_prev_q <= 1'b0;
            tick_q     <= 1'b0;
            state_q    <= ST_INIT;
            dir_q      <= DIR_RIGHT;
            count_q    <= '0;
            level_q    <= '0;
            grow_cnt_q <= '0;
            score_q    <= '0;
        end else begin
            ref_meta_q <= refresh_i;
            ref_sync_q <= ref_meta_q;
            ref_prev_q <= ref_sync_q;
            tick_q     <= ref_sync_q & ~ref_prev_q;
            state_q    <= state_d;
            dir_q      <= dir_d;
            count_q    <= count_d;
            level_q    <= level_d;
            grow_cnt_q <= grow_cnt_d;
            score_q    <= score_d;
        end
    end

    // The level is clamped at START-MIN, so the subtraction is the max() of the two limits.
    assign frames = START_C - level_q;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        count_d    = count_q;
        level_d    = level_q;
        grow_cnt_d = grow_cnt_q;
        score_d    = score_q;
        if (restart_i) begin
            state_d    = ST_INIT;
            dir_d      = DIR_RIGHT;
            count_d    = '0;
            level_d    = '0;
            grow_cnt_d = '0;
            score_d    = '0;
        end else begin
            case (state_q)
                ST_INIT: if (step_ack_i) state_d = ST_READY;
                ST_READY: begin
                    if (turn) begin
                        state_d = ST_RUN;
                        count_d = '0;
                    end
                end
                ST_RUN: begin
                    if (tick_q) begin
                        if (count_q == frames - 1'b1) begin
                            state_d = ST_STEP;
                            count_d = '0;
                            dir_d   = pending_dir;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    if (step_ack_i) begin
                        if (collision_i) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_RUN;
                            if (grow_i) begin
                                if (score_q != '1) score_d = score_q + 1'b1;
                                if (grow_cnt_q == GROW_LAST) begin
                                    grow_cnt_d = '0;
                                    if (level_q < MAX_LVL) level_d = level_q + 1'b1;
                                end else begin
                                    grow_cnt_d = grow_cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_OVER: state_d = ST_OVER;
                default: state_d = ST_INIT;
            endcase
        end
    end

    // restart masks step_req combinationally so the request drops in the same cycle.
    assign init_req_o   = (state_q == ST_INIT);
    assign step_req_o   = (state_q == ST_STEP) && !restart_i;
    assign dir_o        = dir_q;
    assign game_state_o = game_code(state_q);
    assign score_o      = score_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Directed bench for snake_step_scheduler: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_snake_step_scheduler;

    logic       clk = 1'b0;
    logic       rst, refresh, restart;
    logic       sw_up, sw_down, sw_left, sw_right;
    logic       step_ack, collision, grow;
    logic       init_req, step_req;
    logic [1:0] dir, game_state;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_step_scheduler dut (
        .vga_clk_i    (clk),
        .rst_i        (rst),
        .refresh_i    (refresh),
        .restart_i    (restart),
        .sw_up_i      (sw_up),
        .sw_down_i    (sw_down),
        .sw_left_i    (sw_left),
        .sw_right_i   (sw_right),
        .step_ack_i   (step_ack),
        .collision_i  (collision),
        .grow_i       (grow),
        .init_req_o   (init_req),
        .step_req_o   (step_req),
        .dir_o        (dir),
        .game_state_o (game_state),
        .score_o      (score)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic refresh_pulse();
        refresh = 1'b1;
        cyc(4);
        refresh = 1'b0;
        cyc(4);
    endtask

    // Returns the refresh edge number at which step_req appeared, 0 if it never did.
    task automatic run_to_step(output int n);
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            refresh_pulse();
            if (step_req === 1'b1) n = i;
        end
    endtask

    task automatic raw_ack();
        step_ack = 1'b1;
        cyc(1);
        step_ack = 1'b0;
        cyc(1);
    endtask

    task automatic ack_step(input logic col, input logic grw);
        int w;
        w = 0;
        while (step_req !== 1'b1 && w < 50) begin
            cyc(1);
            w++;
        end
        checks++;
        if (step_req !== 1'b1) begin
            errors++;
            $display("FAIL ack_wait: step_req=%b required 1", step_req);
        end
        step_ack  = 1'b1;
        collision = col;
        grow      = grw;
        cyc(1);
        step_ack  = 1'b0;
        collision = 1'b0;
        grow      = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        checks++; if (init_req !== 1'b1)    begin errors++; $display("FAIL rst_init_req: got %b required 1", init_req); end
        checks++; if (step_req !== 1'b0)    begin errors++; $display("FAIL rst_step_req: got %b required 0", step_req); end
        checks++; if (score !== 8'd0)       begin errors++; $display("FAIL rst_score: got %0d required 0", score); end
        checks++; if (dir !== 2'b11)        begin errors++; $display("FAIL rst_dir: got %0d required 3", dir); end
        checks++; if (game_state !== 2'd0)  begin errors++; $display("FAIL rst_state: got %0d required 0", game_state); end
        rst = 1'b0;
        cyc(2);
        raw_ack();
        checks++; if (game_state !== 2'd1)  begin errors++; $display("FAIL init_ack_state: got %0d required 1", game_state); end
        checks++; if (init_req !== 1'b0)    begin errors++; $display("FAIL init_ack_req: got %b required 0", init_req); end
    endtask

    task automatic test_ready_filter();
        int n;
        sw_left = 1'b1;
        cyc(6);
        sw_left = 1'b0;
        cyc(3);
        checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL reverse_ignored: state %0d required 1", game_state); end
        sw_up = 1'b1;
        sw_right = 1'b1;
        cyc(5);
        sw_up = 1'b0;
        sw_right = 1'b0;
        cyc(3);
        checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL ready_to_run: state %0d required 2", game_state); end
        run_to_step(n);
        checks++; if (n != 8)              begin errors++; $display("FAIL first_step_edges: got %0d required 8", n); end
        checks++; if (dir !== 2'b00)       begin errors++; $display("FAIL first_step_dir: got %0d required 0", dir); end
        checks++; if (init_req !== 1'b0)   begin errors++; $display("FAIL req_exclusive: init_req %b required 0", init_req); end
    endtask

    task automatic test_ack_hold();
        int n;
        repeat (3) refresh_pulse();
        checks++; if (step_req !== 1'b1)   begin errors++; $display("FAIL hold_step_req: got %b required 1", step_req); end
        checks++; if (dir !== 2'b00)       begin errors++; $display("FAIL hold_dir: got %0d required 0", dir); end
        ack_step(1'b0, 1'b0);
        checks++; if (step_req !== 1'b0)   begin errors++; $display("FAIL ack_drops_req: got %b required 0", step_req); end
        checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL ack_back_run: state %0d required 2", game_state); end
        run_to_step(n);
        checks++; if (n != 8)              begin errors++; $display("FAIL no_queued_step: edges %0d required 8", n); end
    endtask

    task automatic test_grow();
        int n, lvl, exp_n;
        for (int k = 1; k <= 28; k++) begin
            ack_step(1'b0, 1'b1);
            if (k == 4) begin
                checks++; if (score !== 8'd4) begin errors++; $display("FAIL score_after_4: got %0d required 4", score); end
            end
            run_to_step(n);
            lvl   = (k / 4 > 6) ? 6 : k / 4;
            exp_n = 8 - lvl;
            checks++;
            if (n != exp_n) begin
                errors++;
                $display("FAIL frames_after_grow%0d: edges %0d required %0d", k, n, exp_n);
            end
        end
        checks++; if (score !== 8'd28) begin errors++; $display("FAIL score_after_28: got %0d required 28", score); end
    endtask

    task automatic test_over();
        ack_step(1'b1, 1'b1);
        checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL over_state: got %0d required 3", game_state); end
        checks++; if (score !== 8'd28)     begin errors++; $display("FAIL over_score: got %0d required 28", score); end
        repeat (10) refresh_pulse();
        checks++; if (step_req !== 1'b0)   begin errors++; $display("FAIL over_no_step: got %b required 0", step_req); end
        raw_ack();
        checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL over_ack_ignored: got %0d required 3", game_state); end
    endtask

    task automatic test_restart_ack();
        int n;
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL restart_from_over: got %0d required 0", game_state); end
        checks++; if (score !== 8'd0)      begin errors++; $display("FAIL restart_score: got %0d required 0", score); end
        raw_ack();
        sw_down = 1'b1;
        sw_left = 1'b1;
        cyc(5);
        sw_down = 1'b0;
        sw_left = 1'b0;
        cyc(3);
        run_to_step(n);
        checks++; if (n != 8)              begin errors++; $display("FAIL restart_speed_reset: edges %0d required 8", n); end
        checks++; if (dir !== 2'b01)       begin errors++; $display("FAIL priority_down: dir %0d required 1", dir); end
        ack_step(1'b0, 1'b1);
        run_to_step(n);
        restart  = 1'b1;
        step_ack = 1'b1;
        grow     = 1'b1;
        #1;
        checks++; if (step_req !== 1'b0)   begin errors++; $display("FAIL restart_immediate: step_req %b required 0", step_req); end
        cyc(1);
        restart  = 1'b0;
        step_ack = 1'b0;
        grow     = 1'b0;
        checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL restart_wins_state: got %0d required 0", game_state); end
        checks++; if (score !== 8'd0)      begin errors++; $display("FAIL restart_wins_score: got %0d required 0", score); end
        checks++; if (dir !== 2'b11)       begin errors++; $display("FAIL restart_dir: got %0d required 3", dir); end
        checks++; if (init_req !== 1'b1)   begin errors++; $display("FAIL restart_init_req: got %b required 1", init_req); end
    endtask

    task automatic test_saturation();
        int n;
        raw_ack();
        raw_ack();
        checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL ready_ack_ignored: got %0d required 1", game_state); end
        sw_up = 1'b1;
        cyc(5);
        sw_up = 1'b0;
        cyc(3);
        for (int k = 0; k < 255; k++) begin
            run_to_step(n);
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL sat_step_timeout: grow %0d got no step_req", k);
            end
            ack_step(1'b0, 1'b1);
        end
        checks++; if (score !== 8'd255)    begin errors++; $display("FAIL score_255: got %0d required 255", score); end
        run_to_step(n);
        ack_step(1'b0, 1'b1);
        checks++; if (score !== 8'd255)    begin errors++; $display("FAIL score_saturate: got %0d required 255", score); end
        checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL sat_state: got %0d required 2", game_state); end
    endtask

    initial begin
        rst = 1'b1; refresh = 1'b0; restart = 1'b0;
        sw_up = 1'b0; sw_down = 1'b0; sw_left = 1'b0; sw_right = 1'b0;
        step_ack = 1'b0; collision = 1'b0; grow = 1'b0;
        test_reset();
        test_ready_filter();
        test_ack_hold();
        test_grow();
        test_over();
        test_restart_ack();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
